// File: rtl/spi_rx_if.sv
// spi_rx_if: bundles the serial lines coming from spi_tx and the word-level
// valid/ready handshake toward the consumer.
//   spi_cs / spi_clk / spi_data : raw serial lines (cs active low, clk idle low)
//   rx_data / rx_valid / rx_ready : show-ahead FIFO head and pop handshake
//   frame_err / overflow          : one-cycle status pulses
//   busy                          : frame in progress
// The slave modport is the receiver side; the master modport is the environment
// that drives the serial lines and consumes words.
interface spi_rx_if #(
  parameter int DATA_W = 24
);
  logic              spi_cs;
  logic              spi_clk;
  logic              spi_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overflow;
  logic              busy;

  modport slave (
    input  spi_cs, spi_clk, spi_data, rx_ready,
    output rx_data, rx_valid, frame_err, overflow, busy
  );

  modport master (
    output spi_cs, spi_clk, spi_data, rx_ready,
    input  rx_data, rx_valid, frame_err, overflow, busy
  );
endinterface

// File: rtl/spi_rx.sv
// spi_rx: oversampling SPI receiver. Synchronizes cs/clk/data into the clk
// domain, shifts in MSB-first DATA_W-bit words on synchronized spi_clk rising
// edges, and queues completed words in a show-ahead FIFO drained by valid/ready.
// Ports:
//   clk  - single clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - spi_rx_if.slave (serial lines in, word handshake and status out)
module spi_rx #(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     RST,
  spi_rx_if.slave  bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  // ---------------- synchronizers + edge history ----------------
  logic [SYNC_STAGES-1:0] r_cs_sync, r_clk_sync, r_dat_sync;
  logic                   r_cs_q, r_clk_q;
  logic                   w_cs, w_sclk, w_dat;
  logic                   w_cs_fall, w_cs_rise, w_clk_rise;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_cs_sync  <= '1;
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_cs_q     <= 1'b1;
      r_clk_q    <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  bus.spi_cs};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.spi_data};
      r_cs_q     <= w_cs;
      r_clk_q    <= w_sclk;
    end
  end

  // Data needs no edge history: it is only sampled on clk edges.
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk     = r_clk_sync[SYNC_STAGES-1];
  assign w_dat      = r_dat_sync[SYNC_STAGES-1];
  assign w_cs_fall  =  r_cs_q & ~w_cs;
  assign w_cs_rise  = ~r_cs_q &  w_cs;
  assign w_clk_rise =  w_sclk & ~r_clk_q;

  // ---------------- frame FSM ----------------
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_start, w_shift, w_end, w_ferr_set, w_busy;

  always_ff @(posedge clk) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_cs_fall) w_state_nxt = S_RECV;
      S_RECV: if (w_cs_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start    = (r_state == S_IDLE) && w_cs_fall;
    w_shift    = (r_state == S_RECV) && w_clk_rise;
    w_end      = (r_state == S_RECV) && w_cs_rise;
    w_ferr_set = w_end && (r_cnt != '0);
    // Registered state makes busy drop on the same edge frame_err rises.
    w_busy     = (r_state == S_RECV);
  end

  // ---------------- shift register / bit counter ----------------
  logic [DATA_W-1:0] r_shift, r_wr_data;
  logic              r_wr_req, r_ferr;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_wr_data <= '0;
      r_wr_req  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_wr_req <= 1'b0;
      r_ferr   <= w_ferr_set;
      if (w_start || w_end) begin
        // partial bits of a short frame are simply dropped here
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[DATA_W-2:0], w_dat};
        if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_wr_req  <= 1'b1;
          r_wr_data <= {r_shift[DATA_W-2:0], w_dat};
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic              r_ovf;
  logic              w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.rx_ready;
  // A pop in the same cycle frees the slot the push would otherwise lack.
  assign w_push  = r_wr_req && (!w_full || w_pop);
  assign w_drop  = r_wr_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= r_wr_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign bus.rx_data   = r_mem[r_rptr[AW-1:0]];
  assign bus.rx_valid  = !w_empty;
  assign bus.frame_err = r_ferr;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_spi_rx.sv
module tb_spi_rx;
  localparam int DATA_W      = 24;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // spi_clk half period in clk cycles

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  spi_rx_if #(.DATA_W(DATA_W)) bus();

  spi_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr, n_ovf;
  bit rnd_stop;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];

  // Observe handshakes and pulses half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got_q.push_back(bus.rx_data);
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.overflow  === 1'b1) n_ovf++;
  end

  task automatic clr();
    got_q.delete(); exp_q.delete(); n_ferr = 0; n_ovf = 0;
  endtask

  task automatic cs_low();
    @(posedge clk); #1 bus.spi_cs = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_high();
    @(posedge clk); #1 bus.spi_cs = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1 bus.spi_data = b;
    repeat (HALF-1) @(posedge clk); #1 bus.spi_clk = 1'b1;
    repeat (HALF) @(posedge clk); #1 bus.spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[DATA_W-1-i]);
  endtask

  // Pop until empty, bounded.
  task automatic drain(output bit timeout);
    @(posedge clk); #1 bus.rx_ready = 1'b1;
    timeout = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (!bus.rx_valid) begin timeout = 1'b0; break; end
    end
    bus.rx_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    n_cmp++; if (bus.rx_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.rx_data); end
    n_cmp++; if (bus.frame_err !== 1'b0 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ferr=%b ovf=%b want 0 0", bus.frame_err, bus.overflow); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    RST = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] w;
    bit to;
    clr();
    w = 24'h28bb85;
    exp_q.push_back(w);
    bus.rx_ready = 1'b1;
    cs_low();
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    send_bits(w, DATA_W-1);
    // last bit by hand to watch the write latency
    @(posedge clk); #1 bus.spi_data = w[0];
    repeat (HALF-1) @(posedge clk); #1 bus.spi_clk = 1'b1;
    repeat (SYNC_STAGES+1) @(posedge clk); #1;
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", bus.rx_valid); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== w) begin n_bad++; $display("FAIL single_latency: got v=%b d=%h want v=1 d=%h", bus.rx_valid, bus.rx_data, w); end
    repeat (HALF-SYNC_STAGES-2) @(posedge clk); #1 bus.spi_clk = 1'b0;
    cs_high();
    bus.rx_ready = 1'b0;
    drain(to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL single_drain: timed out, want empty"); end
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== w) begin n_bad++; $display("FAIL single_word: got %0d words first=%h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, w); end
    n_cmp++; if (n_ferr != 0 || n_ovf != 0) begin n_bad++; $display("FAIL single_flags: got ferr=%0d ovf=%0d want 0 0", n_ferr, n_ovf); end
  endtask

  task automatic test_multi();
    bit to;
    clr();
    exp_q.push_back(24'h000fff); exp_q.push_back(24'h555555); exp_q.push_back(24'h123456);
    cs_low();
    foreach (exp_q[i]) send_bits(exp_q[i], DATA_W);
    cs_high();
    #1;
    n_cmp++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp_q[0]) begin n_bad++; $display("FAIL multi_head: got v=%b d=%h want v=1 d=%h", bus.rx_valid, bus.rx_data, exp_q[0]); end
    drain(to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL multi_drain: timed out, want empty"); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL multi_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL multi_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] w;
    int exp_ovf;
    bit to;
    clr();
    exp_ovf = 0;
    cs_low();
    for (int i = 0; i < FIFO_DEPTH+1; i++) begin
      w = DATA_W'($urandom);
      if (i < FIFO_DEPTH) exp_q.push_back(w); else exp_ovf++;
      send_bits(w, DATA_W);
    end
    cs_high();
    n_cmp++; if (n_ovf != exp_ovf) begin n_bad++; $display("FAIL ovf_pulses: got %0d want %0d", n_ovf, exp_ovf); end
    drain(to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL ovf_drain: timed out, want empty"); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
  endtask

  task automatic test_short_frame();
    logic [DATA_W-1:0] junk;
    bit to;
    clr();
    junk = DATA_W'($urandom);
    cs_low();
    send_bits(junk, 10);
    cs_high();
    n_cmp++; if (n_ferr != 1) begin n_bad++; $display("FAIL short_ferr: got %0d pulses want 1", n_ferr); end
    n_cmp++; if (got_q.size() != 0 || bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL short_valid: got %0d words v=%b want 0 0", got_q.size(), bus.rx_valid); end
    exp_q.push_back(24'h123456);
    bus.rx_ready = 1'b1;
    cs_low();
    send_bits(24'h123456, DATA_W);
    cs_high();
    drain(to);
    n_cmp++; if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL short_next: got %0d words first=%h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
    n_cmp++; if (n_ferr != 1) begin n_bad++; $display("FAIL short_ferr_after: got %0d pulses want 1", n_ferr); end
  endtask

  task automatic test_full_pop();
    logic [DATA_W-1:0] w;
    bit to;
    clr();
    cs_low();
    for (int i = 0; i < FIFO_DEPTH+1; i++) begin
      w = DATA_W'($urandom);
      exp_q.push_back(w);
      if (i < FIFO_DEPTH) send_bits(w, DATA_W);
    end
    send_bits(w, DATA_W-1);
    // last bit: hold rx_ready for exactly the edge that writes the new word
    @(posedge clk); #1 bus.spi_data = w[0];
    repeat (HALF-1) @(posedge clk); #1 bus.spi_clk = 1'b1;
    repeat (SYNC_STAGES+1) @(posedge clk); #1 bus.rx_ready = 1'b1;
    @(posedge clk); #1 bus.rx_ready = 1'b0;
    repeat (HALF-SYNC_STAGES-2) @(posedge clk); #1 bus.spi_clk = 1'b0;
    cs_high();
    n_cmp++; if (n_ovf != 0) begin n_bad++; $display("FAIL fullpop_ovf: got %0d pulses want 0", n_ovf); end
    n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL fullpop_popped: got %0d want 1", got_q.size()); end
    drain(to);
    n_cmp++; if (to || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fullpop_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clr();
    cs_low();
    send_bits(DATA_W'($urandom), DATA_W);
    send_bits(DATA_W'($urandom), DATA_W);
    send_bits(DATA_W'($urandom), 12);
    #1;
    n_cmp++; if (bus.rx_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %b want 1", bus.rx_valid); end
    @(posedge clk); #1 RST = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_clear: got v=%b busy=%b want 0 0", bus.rx_valid, bus.busy); end
    bus.spi_cs = 1'b1;
    repeat (4) @(posedge clk); #1 RST = 1'b0;
    repeat (4) @(posedge clk);
    exp_q.push_back(24'h28bb85);
    bus.rx_ready = 1'b1;
    cs_low();
    send_bits(24'h28bb85, DATA_W);
    cs_high();
    drain(to);
    n_cmp++; if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_next: got %0d words first=%h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
    n_cmp++; if (n_ferr != 0 || n_ovf != 0) begin n_bad++; $display("FAIL rstmid_flags: got ferr=%0d ovf=%0d want 0 0", n_ferr, n_ovf); end
  endtask

  // Random frames of 1..FIFO_DEPTH words with random consumer stalls; the FIFO
  // starts empty so nothing can overflow and every word must arrive in order.
  task automatic test_random();
    logic [DATA_W-1:0] w;
    int nw;
    bit to;
    clr();
    for (int f = 0; f < 4; f++) begin
      nw = $urandom_range(1, FIFO_DEPTH);
      rnd_stop = 1'b0;
      fork
        begin
          cs_low();
          for (int i = 0; i < nw; i++) begin
            w = DATA_W'($urandom);
            exp_q.push_back(w);
            send_bits(w, DATA_W);
          end
          cs_high();
          rnd_stop = 1'b1;
        end
        begin
          while (!rnd_stop) begin
            @(posedge clk); #1 bus.rx_ready = ($urandom_range(0, 1) == 1);
          end
        end
      join
      drain(to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL rand_drain%0d: timed out, want empty", f); end
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
    n_cmp++; if (n_ferr != 0 || n_ovf != 0) begin n_bad++; $display("FAIL rand_flags: got ferr=%0d ovf=%0d want 0 0", n_ferr, n_ovf); end
  endtask

  initial begin
    bus.spi_cs   = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_data = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_short_frame();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
